// File: rtl/multicycle_subtractor_if.sv
// Handshake and operand/result bundle for the digit-serial subtractor.
// The master issues start with operands; the slave returns busy/done and the result.
interface multicycle_subtractor_if #(
   parameter int W = 16
);
   logic         start;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         bout;
   logic         ovf;

   modport master (
      output start, x, y, bin,
      input  busy, done, d, bout, ovf
   );

   modport slave (
      input  start, x, y, bin,
      output busy, done, d, bout, ovf
   );
endinterface

// File: rtl/multicycle_subtractor.sv
// Digit-serial subtractor: d = x - y - bin over W bits, one D-bit digit per clock,
// LSB digit first, with a start/busy/done handshake and registered results.
module multicycle_subtractor #(
   parameter int W = 16,
   parameter int D = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   multicycle_subtractor_if.slave bus
);

   localparam int N  = W / D;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (D < 1 || D > W) begin : g_bad_digit
         $error("multicycle_subtractor: D must be in 1..W");
      end else if ((W % D) != 0) begin : g_bad_ratio
         $error("multicycle_subtractor: W must be a multiple of D");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [W-1:0]  x_sh, y_sh;
   logic          x_sign, y_sign;
   logic [W-1:0]  part;
   logic          borrow;
   logic [CW-1:0] cnt;
   logic [W-1:0]  d_q;
   logic          bout_q, ovf_q;

   logic [D:0]    digit;
   logic [W-1:0]  part_nx;
   logic          last;

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      digit   = {1'b0, x_sh[D-1:0]} - {1'b0, y_sh[D-1:0]} - {{D{1'b0}}, borrow};
      // New digit enters at the top; after N shifts the partial holds the full result.
      part_nx = W'({digit[D-1:0], part} >> D);
      last    = (cnt == CW'(N - 1));
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (bus.start) state_nx = RUN;
         RUN:     if (last)      state_nx = DONE;
         DONE:                   state_nx = IDLE;
         default:                state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // NOTE: operand and partial registers are reset too, so an aborted run leaves no stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_sh   <= '0;
         y_sh   <= '0;
         x_sign <= 1'b0;
         y_sign <= 1'b0;
         part   <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         d_q    <= '0;
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  x_sh   <= bus.x;
                  y_sh   <= bus.y;
                  x_sign <= bus.x[W-1];
                  y_sign <= bus.y[W-1];
                  part   <= '0;
                  borrow <= bus.bin;
                  cnt    <= '0;
               end
            end
            RUN: begin
               x_sh   <= x_sh >> D;
               y_sh   <= y_sh >> D;
               part   <= part_nx;
               borrow <= digit[D];
               if (last) begin
                  cnt    <= '0;
                  d_q    <= part_nx;
                  bout_q <= digit[D];
                  ovf_q  <= (x_sign != y_sign) && (part_nx[W-1] != x_sign);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = (state == DONE);
   assign bus.d    = d_q;
   assign bus.bout = bout_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_subtractor.sv
// Directed and random bench for multicycle_subtractor (W=16, D=4) with a result
// scoreboard: expectations are pushed at start and popped when done pulses.
module tb_multicycle_subtractor;

   localparam int W   = 16;
   localparam int D   = 4;
   localparam int LAT = W / D + 1;

   typedef struct {
      logic [W-1:0] d;
      logic         bout;
      logic         ovf;
   } exp_t;

   logic clk;
   logic rst_n;

   multicycle_subtractor_if #(.W(W)) bus ();

   multicycle_subtractor #(.W(W), .D(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t sb[$];
   exp_t last_exp;
   int   n_checks  = 0;
   int   n_pass    = 0;
   int   cyc       = 0;
   int   done_cnt  = 0;
   int   last_done = 0;

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c);
      exp_t       r;
      logic [W:0] full;
      full   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c};
      r.d    = full[W-1:0];
      r.bout = full[W];
      r.ovf  = (a[W-1] != b[W-1]) && (r.d[W-1] != a[W-1]);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check_true(input string tag, input logic cond);
      n_checks++;
      assert (cond === 1'b1) n_pass++;
      else $error("FAIL %s: observed %b expected 1", tag, cond);
   endtask

   // Advance to the next falling edge and retire a result if done is high.
   task automatic step();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (bus.done === 1'b1) begin
         done_cnt++;
         last_done = cyc;
         check_true("result_expected_at_done", sb.size() > 0);
         if (sb.size() > 0) begin
            e        = sb.pop_front();
            last_exp = e;
            check("d", 32'(bus.d), 32'(e.d));
            check("bout", 32'(bus.bout), 32'(e.bout));
            check("ovf", 32'(bus.ovf), 32'(e.ovf));
         end
      end
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      int guard;
      int n0;
      int acc;
      int busy_cycles;
      guard = 0;
      while (bus.busy !== 1'b0 && guard < 20) begin
         step();
         guard++;
      end
      check_true("idle_before_start", bus.busy === 1'b0);
      bus.x     = a;
      bus.y     = b;
      bus.bin   = c;
      bus.start = 1'b1;
      sb.push_back(model(a, b, c));
      n0  = done_cnt;
      acc = cyc;
      step();
      bus.start = 1'b0;
      bus.x     = W'($urandom);
      bus.y     = W'($urandom);
      bus.bin   = 1'($urandom);
      busy_cycles = (bus.busy === 1'b1) ? 1 : 0;
      guard = 0;
      while (done_cnt == n0 && guard < 30) begin
         step();
         guard++;
         if (bus.busy === 1'b1) busy_cycles++;
      end
      check_true("done_seen", done_cnt != n0);
      check("latency", 32'(last_done - acc), 32'(LAT));
      check("busy_cycles", 32'(busy_cycles), 32'(LAT));
      step();
      check("done_pulse_width", 32'(bus.done), 32'd0);
      check("busy_after_done", 32'(bus.busy), 32'd0);
      check("d_hold", 32'(bus.d), 32'(last_exp.d));
   endtask

   initial begin
      int guard;
      int prev;
      int prev_done_cyc;
      int n0;

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.x     = '0;
      bus.y     = '0;
      bus.bin   = 1'b0;
      step();
      step();
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_d", 32'(bus.d), 32'd0);
      check("reset_bout", 32'(bus.bout), 32'd0);
      check("reset_ovf", 32'(bus.ovf), 32'd0);
      rst_n = 1'b1;
      step();

      run_op(16'h1234, 16'h0234, 1'b0);
      run_op(16'h0000, 16'h0001, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b0);
      run_op(16'h7FFF, 16'hFFFF, 1'b0);
      run_op(16'h0005, 16'h0005, 1'b1);
      run_op(16'hFFFF, 16'h0000, 1'b1);

      // Results must hold across idle cycles with changing inputs.
      for (int i = 0; i < 4; i++) begin
         bus.x = W'($urandom);
         bus.y = W'($urandom);
         step();
      end
      check("d_hold_idle", 32'(bus.d), 32'(last_exp.d));

      // start held high: one result every LAT+1 cycles from operands at acceptance.
      bus.start     = 1'b1;
      n0            = done_cnt;
      prev_done_cyc = 0;
      for (int i = 0; i < 30; i++) begin
         bus.x   = W'($urandom);
         bus.y   = W'($urandom);
         bus.bin = 1'($urandom);
         if (bus.busy === 1'b0) sb.push_back(model(bus.x, bus.y, bus.bin));
         prev = done_cnt;
         step();
         if (done_cnt != prev) begin
            if (done_cnt > n0 + 1) check("start_held_period", 32'(cyc - prev_done_cyc), 32'(LAT + 1));
            prev_done_cyc = cyc;
         end
      end
      bus.start = 1'b0;
      guard = 0;
      while (sb.size() > 0 && guard < 20) begin
         step();
         guard++;
      end
      check("start_held_drained", 32'(sb.size()), 32'd0);
      check_true("start_held_results", done_cnt >= n0 + 4);

      // Reset asserted mid-RUN aborts without a done pulse.
      run_op(16'hABCD, 16'h1234, 1'b1);
      bus.x     = 16'h4321;
      bus.y     = 16'h0021;
      bus.bin   = 1'b0;
      bus.start = 1'b1;
      sb.push_back(model(bus.x, bus.y, bus.bin));
      step();
      bus.start = 1'b0;
      step();
      rst_n = 1'b0;
      sb.delete();
      step();
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_d", 32'(bus.d), 32'd0);
      check("abort_bout", 32'(bus.bout), 32'd0);
      check("abort_ovf", 32'(bus.ovf), 32'd0);
      rst_n = 1'b1;
      n0 = done_cnt;
      for (int i = 0; i < 8; i++) step();
      check("no_done_after_abort", 32'(done_cnt - n0), 32'd0);
      run_op(16'h4321, 16'h0021, 1'b0);

      for (int i = 0; i < 300; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
